// File: rtl/rotor_pkg.sv
// rotor_pkg -- shared types and constants for the rotor scheduler.
//   state_e   : scheduler FSM encoding
//   DIR_*     : rotate direction encoding of req_dir bits
//   ROT_W     : rotor register width
//   AMT_W     : rotate count width
//   NUM_REQ   : number of requesters
package rotor_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROTATE,
    S_RESP
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned ROT_W   = 8;
  localparam int unsigned AMT_W   = 3;
  localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/rotor_rr_arb.sv
// rotor_rr_arb -- 2-way round-robin arbiter.
//   clk, rst_n  : clock, async active-low reset
//   req_i       : request vector (bit i = requester i)
//   advance_i   : grant consumed this cycle; records grant_o as last grant
//   valid_o     : some request is present
//   grant_o     : index of granted requester
// last_grant resets to 1 so requester 0 wins the first conflict.
module rotor_rr_arb
  import rotor_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic               valid_o,
  output logic               grant_o
);

  logic last_q;

  always_comb begin
    valid_o = |req_i;
    case (req_i)
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_q;
      default: grant_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance_i) begin
      last_q <= grant_o;
    end
  end

endmodule

// File: rtl/rotor_sched.sv
// rotor_sched -- arbitrates two requesters onto an external rotate register.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : per-requester command handshake
//   req_load/dir/amt/data : per-requester command fields
//   rot_load/right/left, rot_in : rotor control strobes and load data
//   rot_out             : current rotor value
//   rsp_valid/ready/id/data : result handshake
//   busy                : FSM not in IDLE
module rotor_sched
  import rotor_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_load,
  input  logic [NUM_REQ-1:0]       req_dir,
  input  logic [NUM_REQ*AMT_W-1:0] req_amt,
  input  logic [NUM_REQ*ROT_W-1:0] req_data,
  output logic                     rot_load,
  output logic                     rot_right,
  output logic                     rot_left,
  output logic [ROT_W-1:0]         rot_in,
  input  logic [ROT_W-1:0]         rot_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [ROT_W-1:0]         rsp_data,
  output logic                     busy
);

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic               dir_q, dir_d;
  logic               id_q, id_d;
  logic [ROT_W-1:0]   data_q, data_d;

  logic               arb_valid;
  logic               gnt;
  logic               accept;
  logic               sel_load;
  logic [AMT_W-1:0]   sel_amt;

  assign accept   = (state_q == S_IDLE) && arb_valid;
  assign sel_load = req_load[gnt];
  assign sel_amt  = gnt ? req_amt[2*AMT_W-1:AMT_W] : req_amt[AMT_W-1:0];

  rotor_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .advance_i (accept),
    .valid_o   (arb_valid),
    .grant_o   (gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    amt_d     = amt_q;
    dir_d     = dir_q;
    id_d      = id_q;
    data_d    = data_q;
    req_ready = '0;
    rot_load  = 1'b0;
    rot_right = 1'b0;
    rot_left  = 1'b0;
    rot_in    = '0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_data  = '0;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          req_ready[gnt] = 1'b1;
          amt_d  = sel_amt;
          dir_d  = req_dir[gnt];
          id_d   = gnt;
          data_d = gnt ? req_data[2*ROT_W-1:ROT_W] : req_data[ROT_W-1:0];
          cnt_d  = sel_amt;
          if (sel_load)            state_d = S_LOAD;
          else if (sel_amt != '0)  state_d = S_ROTATE;
          else                     state_d = S_RESP;
        end
      end
      S_LOAD: begin
        rot_load = 1'b1;
        rot_in   = data_q;
        cnt_d    = amt_q;
        state_d  = (amt_q != '0) ? S_ROTATE : S_RESP;
      end
      S_ROTATE: begin
        rot_left  = (dir_q == DIR_LEFT);
        rot_right = (dir_q == DIR_RIGHT);
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = rot_out;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      amt_q   <= '0;
      dir_q   <= 1'b0;
      id_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      amt_q   <= amt_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_rotor_sched.sv
// tb_rotor_sched -- directed test of rotor_sched with a behavioural rotor.
module tb_rotor_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_load, req_dir;
  logic [5:0]  req_amt;
  logic [15:0] req_data;
  logic        rot_load, rot_right, rot_left;
  logic [7:0]  rot_in, rot_out;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0]  rsp_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  rotor_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_dir(req_dir), .req_amt(req_amt), .req_data(req_data),
    .rot_load(rot_load), .rot_right(rot_right), .rot_left(rot_left),
    .rot_in(rot_in), .rot_out(rot_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Behavioural rotate register; not reset, so it keeps partial results.
  logic [7:0] rotor_q = 8'h00;
  always @(posedge clk) begin
    if (rot_load)       rotor_q <= rot_in;
    else if (rot_right) rotor_q <= {rotor_q[0], rotor_q[7:1]};
    else if (rot_left)  rotor_q <= {rotor_q[6:0], rotor_q[7]};
  end
  assign rot_out = rotor_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, " req_ready"}, 32'(req_ready), 0);
    check({pfx, " strobes"}, 32'({rot_load, rot_right, rot_left}), 0);
    check({pfx, " rot_in"}, 32'(rot_in), 0);
    check({pfx, " rsp_valid"}, 32'(rsp_valid), 0);
    check({pfx, " rsp_id"}, 32'(rsp_id), 0);
    check({pfx, " rsp_data"}, 32'(rsp_data), 0);
    check({pfx, " busy"}, 32'(busy), 0);
  endtask

  // Issue one command from requester id, then consume the response after
  // holding rsp_ready low for 'hold' cycles.
  task automatic run_cmd(input int unsigned id, input logic ld, input logic dr,
                         input logic [2:0] amt, input logic [7:0] data,
                         input logic [7:0] exp_data, input int unsigned exp_lat,
                         input int unsigned hold);
    int unsigned lat = 0, n_ld = 0, n_l = 0, n_r = 0;
    logic        got = 1'b0;
    logic [7:0]  hid_data;
    @(posedge clk); #1;
    req_load[id] = ld;
    req_dir[id]  = dr;
    req_amt[3*id +: 3]  = amt;
    req_data[8*id +: 8] = data;
    req_valid = 2'b01 << id;
    @(negedge clk);
    check("accept ready", 32'(req_ready), 32'(2'b01 << id));
    check("accept busy", 32'(busy), 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if ((32'(rot_load) + 32'(rot_left) + 32'(rot_right)) > 1)
        check("strobe onehot", 32'({rot_load, rot_right, rot_left}), 0);
      if (rot_load) begin
        n_ld++;
        check("rot_in", 32'(rot_in), 32'(data));
      end
      if (rot_left)  n_l++;
      if (rot_right) n_r++;
      if (rsp_valid) got = 1'b1;
    end
    check("rsp seen", 32'(got), 1);
    check("latency", lat, exp_lat);
    check("load pulses", n_ld, 32'(ld));
    check("left pulses", n_l, dr ? 0 : 32'(amt));
    check("right pulses", n_r, dr ? 32'(amt) : 0);
    check("rsp_id", 32'(rsp_id), id);
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    hid_data = rsp_data;
    for (int h = 0; h < int'(hold); h++) begin
      @(posedge clk); #1;
      req_valid = 2'b11;
      @(negedge clk);
      check("hold rsp_valid", 32'(rsp_valid), 1);
      check("hold rsp_id", 32'(rsp_id), id);
      check("hold rsp_data", 32'(rsp_data), 32'(hid_data));
      check("hold req_ready", 32'(req_ready), 0);
      check("hold strobes", 32'({rot_load, rot_right, rot_left}), 0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("back idle busy", 32'(busy), 0);
    check("back idle rsp_valid", 32'(rsp_valid), 0);
  endtask

  initial begin
    logic        found;
    logic [1:0]  exp_gnt;
    rst_n = 1'b0;
    req_valid = '0; req_load = '0; req_dir = '0; req_amt = '0; req_data = '0;
    rsp_ready = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters hold valid: grants must alternate 0,1,0,1.
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) found = 1'b1;
      end
      check("arb grant seen", 32'(found), 1);
      check("arb grant", 32'(req_ready), 32'(exp_gnt));
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        @(negedge clk);
        if (rsp_valid) found = 1'b1;
      end
      check("arb rsp seen", 32'(found), 1);
      check("arb rsp_id", 32'(rsp_id), 32'(exp_gnt[1]));
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);

    run_cmd(0, 1'b1, 1'b0, 3'd0, 8'hB4, 8'hB4, 2, 0);
    run_cmd(1, 1'b1, 1'b1, 3'd3, 8'h81, 8'h30, 5, 0);
    run_cmd(0, 1'b1, 1'b0, 3'd1, 8'h81, 8'h03, 3, 5);

    // Reset during a 7-step left rotate of 8'h5A: load applied, one left
    // strobe applied, second strobe cancelled by reset -> rotor 8'hB4.
    @(posedge clk); #1;
    req_load[0] = 1'b1; req_dir[0] = 1'b0; req_amt[2:0] = 3'd7; req_data[7:0] = 8'h5A;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("rst seq load", 32'(rot_load), 1);
    @(negedge clk);
    check("rst seq left1", 32'(rot_left), 1);
    @(negedge clk);
    check("rst seq left2", 32'(rot_left), 1);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("midop reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post reset rsp_valid", 32'(rsp_valid), 0);
    run_cmd(0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hB4, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rotor_sched.md
ROTOR_SCHED -- requirements
Module: rotor_sched

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 req_valid  in  2  per-requester command valid; bit i = requester i.
REQ-004 req_ready  out  2  per-requester accept; at most one bit high.
REQ-005 req_load  in  2  command loads req_data into rotor before rotating.
REQ-006 req_dir  in  2  rotate direction; 0 = left, 1 = right.
REQ-007 req_amt  in  6  rotate count 0..7; bits [3i+2:3i] = requester i.
REQ-008 req_data  in  16  load value; bits [8i+7:8i] = requester i.
REQ-009 rot_load, rot_right, rot_left  out  1 each  rotor control strobes.
REQ-010 rot_in  out  8  rotor load data.
REQ-011 rot_out  in  8  current rotor register value.
REQ-012 rsp_valid  out  1  result available.
REQ-013 rsp_ready  in  1  consumer accepts result.
REQ-014 rsp_id  out  1  requester owning the result.
REQ-015 rsp_data  out  8  result value.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, LOAD, ROTATE, RESP.
REQ-018 IDLE: any req_valid high -> arbiter grants one; req_ready[g] high that cycle (combinational from state and grant); command latched on that edge.
REQ-019 Arbitration round-robin: on conflict, grant the requester not granted last; last_grant resets to 1, so requester 0 wins first conflict.
REQ-020 Transitions from IDLE on accept: load=1 -> LOAD; load=0, amt>0 -> ROTATE; load=0, amt=0 -> RESP (read-only).
REQ-021 LOAD: exactly one cycle; rot_load=1, rot_in=latched data; next ROTATE if amt>0, else RESP.
REQ-022 ROTATE: one strobe per cycle (rot_left if dir=0, rot_right if dir=1) for exactly amt consecutive cycles; 3-bit down-counter; last strobe -> RESP.
REQ-023 RESP: rsp_valid=1, rsp_id=granted requester, rsp_data=rot_out; all held stable until rsp_ready=1; that edge -> IDLE.
REQ-024 Latency: rsp_valid first high L+N+1 cycles after accept cycle (L = load bit, N = amt).
REQ-025 At most one of rot_load, rot_right, rot_left high in any cycle; all low outside LOAD/ROTATE; rot_in = 0 outside LOAD.
REQ-026 req_ready all-zero in any state other than IDLE; req_valid changes while busy are ignored.
REQ-027 Requester withdrawing req_valid before grant: no side effect.
REQ-028 No back-to-back accept in RESP->IDLE edge; earliest next accept is the cycle after returning to IDLE.

Reset
REQ-029 rst_n low: state=IDLE, counter=0, last_grant=1, all latched command fields 0, immediately (asynchronous).
REQ-030 Reset values: req_ready=0, rot_load=rot_right=rot_left=0, rot_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
REQ-031 Reset mid-operation aborts the command; no response issued; rotor left holding partial result.

Structure
REQ-032 Package rotor_pkg: state enum, DIR_LEFT=0/DIR_RIGHT=1, ROT_W=8, AMT_W=3, NUM_REQ=2.
REQ-033 Single sub-module rotor_rr_arb: 2-way round-robin arbiter (req, advance -> grant, last_grant register).
REQ-034 Estimated 150-250 RTL lines; bench instantiates rotor_sched with a behavioural 8-bit rotate register on rot_*.

Verification
REQ-035 req0 load=1 data=8'hB4 amt=0 -> one rot_load cycle with rot_in=8'hB4; rsp_valid 2 cycles after accept; rsp_data=8'hB4, rsp_id=0.
REQ-036 req1 load=1 data=8'h81 dir=1 amt=3 -> 3 consecutive rot_right pulses; rsp_data=8'h30, rsp_id=1; latency 5 cycles.
REQ-037 req0 load=1 data=8'h81 dir=0 amt=1 -> one rot_left pulse; rsp_data=8'h03.
REQ-038 Both req_valid held high for 4 commands from reset -> grant order 0,1,0,1; never both req_ready high.
REQ-039 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_id/rsp_data stable, req_ready=0, no rotor strobes; release -> IDLE next cycle.
REQ-040 rst_n low during ROTATE of amt=7 -> all outputs 0 within same cycle, no response; after release, req0 read-only (load=0, amt=0) -> rsp_data equals rot_out.
